// File: rtl/axi_rd_arbiter_ysyx_23060136.sv
// Shares the single AXI4-Lite read port between the IFU and the LSU:
// one outstanding transaction, round-robin on a tie, grant held until the R beat is accepted.
module axi_rd_arbiter_ysyx_23060136 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshakes are strict valid/ready: a beat transfers on the cycle where both
  // valid and ready are high at the rising edge, and a raised valid is never retracted.
  input  logic              ifu_arvalid,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_arready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  input  logic              ifu_rready,
  input  logic              lsu_arvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_arready,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  input  logic              lsu_rready,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  output logic              m_rready,
  output logic              busy,
  output logic              grant_lsu
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]        state;
  logic              owner;
  logic              last;
  logic [ADDR_W-1:0] addr_q;

  logic st_idle, st_addr, st_data;
  logic ifu_win, lsu_win;

  assign st_idle = (state == IDLE);
  assign st_addr = (state == ADDR);
  assign st_data = (state == DATA);

  // On a tie the master that was not served last wins (last=1 means LSU was served).
  assign ifu_win = ifu_arvalid & (~lsu_arvalid | last);
  assign lsu_win = lsu_arvalid & (~ifu_arvalid | ~last);

  // rst_n gates arready so no request is acknowledged while reset is held.
  assign ifu_arready = rst_n & st_idle & ifu_win;
  assign lsu_arready = rst_n & st_idle & lsu_win;

  assign m_arvalid = st_addr;
  assign m_araddr  = addr_q;
  assign m_rready  = st_data & (owner ? lsu_rready : ifu_rready);

  assign ifu_rvalid = st_data & ~owner & m_rvalid;
  assign lsu_rvalid = st_data &  owner & m_rvalid;
  assign ifu_rdata  = m_rdata;
  assign lsu_rdata  = m_rdata;
  assign ifu_rresp  = m_rresp;
  assign lsu_rresp  = m_rresp;

  assign busy      = ~st_idle;
  assign grant_lsu = owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ifu_win || lsu_win) begin
            addr_q <= lsu_win ? lsu_araddr : ifu_araddr;
            owner  <= lsu_win;
            last   <= lsu_win;
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) state <= DATA;
        end
        DATA: begin
          if (m_rvalid && m_rready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter_ysyx_23060136.sv
// Directed bench for the IFU/LSU read arbiter; the downstream slave is driven by hand.
module tb_axi_rd_arbiter_ysyx_23060136;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [1:0]  m_rresp;
  logic        busy, grant_lsu;

  int errors = 0;
  int checks = 0;
  int hs_cnt;

  // clock / reset
  always #5 clk = ~clk;

  axi_rd_arbiter_ysyx_23060136 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .busy(busy), .grant_lsu(grant_lsu)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic exp_lsu [3];
  logic [31:0] exp_addr [3];

  initial begin
    exp_lsu[0] = 1'b1; exp_lsu[1] = 1'b0; exp_lsu[2] = 1'b1;
    exp_addr[0] = 32'h200; exp_addr[1] = 32'h100; exp_addr[2] = 32'h200;

    // ---- reset with a pending IFU request ----
    rst_n = 1'b0;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000; ifu_rready = 1'b0;
    lsu_arvalid = 1'b0; lsu_araddr = 32'h0;         lsu_rready = 1'b0;
    m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    #2;
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_ifu_arready", ifu_arready, 0);
    chk("rst_busy", busy, 0);
    tick(); tick();
    chk("rst_hold_m_arvalid", m_arvalid, 0);
    chk("rst_hold_ifu_arready", ifu_arready, 0);
    chk("rst_grant_lsu", grant_lsu, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_ifu_rvalid", ifu_rvalid, 0);

    // ---- single IFU read, zero-wait slave ----
    rst_n = 1'b1;
    settle();
    chk("ifu_c0_arready", ifu_arready, 1);
    chk("ifu_c0_lsu_arready", lsu_arready, 0);
    tick();
    ifu_arvalid = 1'b0;
    settle();
    chk("ifu_c1_m_arvalid", m_arvalid, 1);
    chk("ifu_c1_m_araddr", m_araddr, 32'h8000_0000);
    chk("ifu_c1_busy", busy, 1);
    chk("ifu_c1_arready", ifu_arready, 0);
    tick();
    m_rvalid = 1'b1; m_rdata = 32'h0000_0413; ifu_rready = 1'b1;
    settle();
    chk("ifu_c2_rvalid", ifu_rvalid, 1);
    chk("ifu_c2_rdata", ifu_rdata, 32'h0000_0413);
    chk("ifu_c2_lsu_rvalid", lsu_rvalid, 0);
    chk("ifu_c2_m_rready", m_rready, 1);
    tick();
    m_rvalid = 1'b0;
    settle();
    chk("ifu_done_busy", busy, 0);

    // ---- persistent tie: expect LSU, IFU, LSU ----
    ifu_arvalid = 1'b1; ifu_araddr = 32'h100;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h200;
    lsu_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("tie%0d_lsu_arready", i), lsu_arready, exp_lsu[i]);
      chk($sformatf("tie%0d_ifu_arready", i), ifu_arready, !exp_lsu[i]);
      tick();
      chk($sformatf("tie%0d_m_araddr", i), m_araddr, exp_addr[i]);
      chk($sformatf("tie%0d_grant_lsu", i), grant_lsu, exp_lsu[i]);
      tick();
      m_rvalid = 1'b1; m_rdata = 32'hA0 + i;
      settle();
      chk($sformatf("tie%0d_lsu_rvalid", i), lsu_rvalid, exp_lsu[i]);
      chk($sformatf("tie%0d_ifu_rvalid", i), ifu_rvalid, !exp_lsu[i]);
      tick();
      m_rvalid = 1'b0;
    end

    // ---- backpressure on AR and R, IFU request while busy ----
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h300; lsu_rready = 1'b0;
    m_arready = 1'b0;
    settle();
    chk("bp_lsu_arready", lsu_arready, 1);
    tick();
    lsu_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("bp_stall%0d_m_arvalid", i), m_arvalid, 1);
      chk($sformatf("bp_stall%0d_m_araddr", i), m_araddr, 32'h300);
      tick();
    end
    m_arready = 1'b1;
    settle();
    chk("bp_accept_m_arvalid", m_arvalid, 1);
    tick();
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b00;
    hs_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) ifu_arvalid = 1'b1;
      ifu_araddr = 32'h100;
      settle();
      chk($sformatf("bp_r%0d_lsu_rvalid", i), lsu_rvalid, 1);
      chk($sformatf("bp_r%0d_m_rready", i), m_rready, 0);
      chk($sformatf("bp_r%0d_ifu_arready", i), ifu_arready, 0);
      if (lsu_rvalid && lsu_rready) hs_cnt++;
      tick();
    end
    lsu_rready = 1'b1;
    settle();
    chk("bp_rel_m_rready", m_rready, 1);
    chk("bp_rel_lsu_rdata", lsu_rdata, 32'hDEAD_BEEF);
    chk("bp_rel_ifu_arready", ifu_arready, 0);
    if (lsu_rvalid && lsu_rready) hs_cnt++;
    tick();
    m_rvalid = 1'b0;
    settle();
    if (lsu_rvalid && lsu_rready) hs_cnt++;
    chk("bp_handshakes", hs_cnt, 1);
    chk("busy_ifu_arready_after", ifu_arready, 1);
    chk("busy_idle", busy, 0);

    // ---- IFU transaction queued above completes ----
    tick();
    ifu_arvalid = 1'b0;
    settle();
    chk("q_ifu_m_araddr", m_araddr, 32'h100);
    chk("q_ifu_grant_lsu", grant_lsu, 0);
    tick();
    m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
    settle();
    chk("q_ifu_rvalid", ifu_rvalid, 1);
    tick();
    m_rvalid = 1'b0;

    // ---- error response passes through, FSM recovers ----
    lsu_arvalid = 1'b1; lsu_araddr = 32'h400;
    settle();
    chk("err_lsu_arready", lsu_arready, 1);
    tick();
    lsu_arvalid = 1'b0;
    tick();
    m_rvalid = 1'b1; m_rresp = 2'b10;
    settle();
    chk("err_lsu_rvalid", lsu_rvalid, 1);
    chk("err_lsu_rresp", lsu_rresp, 2'b10);
    tick();
    m_rvalid = 1'b0; m_rresp = 2'b00;
    settle();
    chk("err_back_idle", busy, 0);

    ifu_arvalid = 1'b1; ifu_araddr = 32'h500; m_arready = 1'b0;
    settle();
    chk("post_err_ifu_arready", ifu_arready, 1);
    tick();
    ifu_arvalid = 1'b0;
    settle();
    chk("post_err_m_araddr", m_araddr, 32'h500);
    chk("post_err_m_arvalid", m_arvalid, 1);

    // ---- asynchronous reset while in ADDR ----
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_m_arvalid", m_arvalid, 0);
    chk("abort_m_araddr", m_araddr, 32'h0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("abort_after_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard time limit so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter_ysyx_23060136.md
Name: axi_rd_arbiter_ysyx_23060136

Overview:
- Arbitrates the single AXI4-Lite read port of the memory subsystem between two requesters: the IFU (instruction fetch) and the LSU (MEM-stage loads).
- Its per-master rvalid returns become the IFU_o_valid / MEM_rvalid inputs of the forward/stall unit, so it decides which pipeline stage stalls.
- Writes bypass this block.
- Policy: one outstanding transaction, round-robin on tie, grant held until the R beat is accepted.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- ifu_arvalid  in  1  IFU read request.
- ifu_araddr  in  ADDR_W  IFU read address.
- ifu_arready  out  1  IFU request accepted.
- ifu_rvalid  out  1  IFU read data valid.
- ifu_rdata  out  DATA_W  IFU read data.
- ifu_rresp  out  2  IFU read response.
- ifu_rready  in  1  IFU ready for data.
- lsu_arvalid, lsu_araddr, lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp, lsu_rready: same directions, widths and meanings as the ifu_* ports, for the LSU.
- m_arvalid  out  1  downstream request.
- m_araddr  out  ADDR_W  downstream address (registered).
- m_arready  in  1  downstream accept.
- m_rvalid  in  1  downstream data valid.
- m_rdata  in  DATA_W  downstream data.
- m_rresp  in  2  downstream response.
- m_rready  out  1  downstream data ready.
- busy  out  1  transaction in flight (state != IDLE).
- grant_lsu  out  1  current or most recent grant owner (1 = LSU, 0 = IFU).

Behaviour:
- FSM states: IDLE, ADDR, DATA. Registers: state, owner, last (last served master), addr_q.
- Reset (async, rst_n=0): state=IDLE, owner=0, last=0 (IFU), addr_q=0. Derived outputs during reset: m_arvalid=0, m_rready=0, all arready=0, all rvalid=0, busy=0.
- IDLE:
  - Only one arvalid high: that master wins.
  - Both high: the master != last wins, so the first tie after reset goes to the LSU.
  - The winner's arready=1 combinationally in the same cycle; the loser's arready=0.
  - On that handshake: addr_q <= winner's araddr, owner <= winner, last <= winner, state <= ADDR.
- ADDR: m_arvalid=1, m_araddr=addr_q. m_arvalid is held until m_arready; it is never retracted. On m_arvalid & m_arready: state <= DATA.
- DATA:
  - owner's rvalid = m_rvalid; the other master's rvalid = 0.
  - m_rready = owner's rready.
  - rdata/rresp are broadcast to both masters; they are meaningful only with rvalid.
  - On m_rvalid & m_rready: state <= IDLE.
- Outside DATA: m_rready=0 and both rvalid=0.
- Outside IDLE: both arready=0. New requests wait; the earliest re-grant is the cycle after the R handshake, so there is no IDLE bypass.
- Minimum latency: request in cycle 0 → m_arvalid in cycle 1 → earliest rvalid at the master in cycle 2, given a zero-wait slave.
- m_rresp is passed through unchanged. Error responses (SLVERR/DECERR) are not retried; the FSM returns to IDLE normally.
- A master dropping arvalid after its arready handshake has no effect; the transaction completes.
- Async reset mid-transaction aborts immediately to IDLE. Any downstream beat still in flight is the slave's responsibility; the slave is reset by the same rst_n.
- busy=1 in ADDR and DATA.
- grant_lsu = owner register.

Test Plan:
- Reset: hold rst_n=0 with ifu_arvalid=1 → m_arvalid=0, ifu_arready=0, busy=0. After release, the IFU is granted in the first cycle.
- Single IFU read: ifu_araddr=0x8000_0000, slave arready=1, returns rdata=0x0000_0413 one cycle later → m_araddr=0x8000_0000 in cycle 1; ifu_rvalid=1 with rdata=0x0000_0413 in cycle 2; lsu_rvalid stays 0.
- Tie after reset: both arvalid=1 every cycle, IFU addr 0x100, LSU addr 0x200 → grants occur in order LSU(0x200), IFU(0x100), LSU(0x200), …; grant_lsu alternates 1,0,1.
- Backpressure: slave arready=0 for 3 cycles, then rvalid with lsu_rready=0 for 2 cycles → m_arvalid and m_araddr stay stable through all 3 stall cycles; m_rready=0 until lsu_rready=1; then exactly one lsu_rvalid&lsu_rready handshake.
- Request during busy: ifu_arvalid is raised while an LSU transaction is in DATA → ifu_arready=0 until the cycle after the LSU R handshake, then 1.
- Error and reset abort:
  - m_rresp=2'b10 → lsu_rresp=2'b10; the next grant proceeds normally.
  - rst_n=0 asserted while in ADDR → busy=0 and m_arvalid=0 in the same cycle.
